// File: rtl/irq_encoder.sv
// Purpose : registered priority encoder; edge-latches request lines into a pending set and offers one masked index at a time.
// Latency : request before edge k sets oPND after edge k, and the offer (oVLD=1) appears after edge k+1; all outputs are registered.
// Backpressure: an offer holds oVLD/oSEL frozen until iACK; ack is followed by at least one oVLD=0 cycle before the next offer.
// Optional: define IRQ_ENCODER_ROTATE_EN for round-robin priority; otherwise the highest index wins.
module irq_encoder #(
    parameter int SEL_SIZE = 3,
    parameter int ONE_COLD = 0,
    localparam int REQ_SIZE = 2 ** SEL_SIZE
) (
    input  logic                iCLK,
    input  logic                iRST,
    input  logic [REQ_SIZE-1:0] iREQ,
    input  logic [REQ_SIZE-1:0] iMSK,
    input  logic                iACK,
    output logic                oVLD,
    output logic [SEL_SIZE-1:0] oSEL,
    output logic [REQ_SIZE-1:0] oPND
);

    typedef enum logic {
        IDLE  = 1'b0,
        OFFER = 1'b1
    } state_t;

    state_t              state;
    logic [REQ_SIZE-1:0] req;
    logic [REQ_SIZE-1:0] msk;
    logic [REQ_SIZE-1:0] req_prev;
    logic [REQ_SIZE-1:0] rise;
    logic [REQ_SIZE-1:0] clr;
    logic [REQ_SIZE-1:0] eligible;
    logic [SEL_SIZE-1:0] win;
    logic                ack_take;

    // Internally everything is active-high; 1-cold inputs are inverted once here.
    assign req = (ONE_COLD != 0) ? ~iREQ : iREQ;
    assign msk = (ONE_COLD != 0) ? ~iMSK : iMSK;

    assign rise     = req & ~req_prev;
    assign ack_take = (state == OFFER) && iACK;
    assign clr      = ack_take ? (REQ_SIZE'(1) << oSEL) : '0;
    // Mask only gates eligibility; pending bits survive while masked.
    assign eligible = oPND & ~msk;

`ifdef IRQ_ENCODER_ROTATE_EN
    logic [SEL_SIZE-1:0] last_grant;

    // Round-robin: search downward starting just below the last granted index, wrapping at zero.
    always_comb begin
        logic                found;
        logic [SEL_SIZE-1:0] idx;
        win   = '0;
        found = 1'b0;
        idx   = '0;
        for (int i = 1; i <= REQ_SIZE; i++) begin
            idx = last_grant - SEL_SIZE'(i);
            if (!found && eligible[idx]) begin
                win   = idx;
                found = 1'b1;
            end
        end
    end

    // Remember which index was last serviced so the search starts below it next time.
    always_ff @(posedge iCLK) begin
        if (iRST) begin
            last_grant <= SEL_SIZE'(REQ_SIZE - 1);
        end else if (ack_take) begin
            last_grant <= oSEL;
        end
    end
`else
    // Fixed priority: the highest eligible index wins (later loop iterations override).
    always_comb begin
        win = '0;
        for (int i = 0; i < REQ_SIZE; i++) begin
            if (eligible[i]) begin
                win = SEL_SIZE'(i);
            end
        end
    end
`endif

    // Edge capture, pending bookkeeping and the offer/ack state machine; a new rise beats a same-cycle clear.
    always_ff @(posedge iCLK) begin
        if (iRST) begin
            state    <= IDLE;
            oVLD     <= 1'b0;
            oSEL     <= '0;
            oPND     <= '0;
            req_prev <= '0;
        end else begin
            req_prev <= req;
            oPND     <= (oPND & ~clr) | rise;
            case (state)
                IDLE: begin
                    if (|eligible) begin
                        oSEL  <= win;
                        oVLD  <= 1'b1;
                        state <= OFFER;
                    end
                end
                OFFER: begin
                    if (iACK) begin
                        oVLD  <= 1'b0;
                        state <= IDLE;
                    end
                end
                default: begin
                    oVLD  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_irq_encoder.sv
// Purpose : directed checks of irq_encoder in active-high and 1-cold builds.
// Latency : one tick = one rising edge; outputs are sampled 1 time unit after the edge.
// Backpressure: ack is driven explicitly per step to exercise hold, ignore-in-idle and same-cycle re-pend.
module tb_irq_encoder;

    logic       clk;
    logic       rst;
    logic [7:0] req;
    logic [7:0] msk;
    logic       ack;
    logic       vld;
    logic [2:0] sel;
    logic [7:0] pnd;

    logic [7:0] req_c;
    logic [7:0] msk_c;
    logic       ack_c;
    logic       vld_c;
    logic [2:0] sel_c;
    logic [7:0] pnd_c;

    int n_cmp = 0;
    int n_err = 0;

    irq_encoder #(.SEL_SIZE(3), .ONE_COLD(0)) u_hot (
        .iCLK(clk), .iRST(rst), .iREQ(req), .iMSK(msk), .iACK(ack),
        .oVLD(vld), .oSEL(sel), .oPND(pnd)
    );

    irq_encoder #(.SEL_SIZE(3), .ONE_COLD(1)) u_cold (
        .iCLK(clk), .iRST(rst), .iREQ(req_c), .iMSK(msk_c), .iACK(ack_c),
        .oVLD(vld_c), .oSEL(sel_c), .oPND(pnd_c)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        rst = 1'b1; req = 8'h01; msk = 8'h00; ack = 1'b0;
        req_c = 8'hFF; msk_c = 8'hFF; ack_c = 1'b0;
        tick(); tick();
        chk("reset_vld", {31'b0, vld}, 32'h0);
        chk("reset_sel", {29'b0, sel}, 32'h0);
        chk("reset_pnd", {24'b0, pnd}, 32'h0);
        chk("reset_pnd_cold", {24'b0, pnd_c}, 32'h0);

        // Line held through reset yields exactly one rise.
        rst = 1'b0;
        tick();
        chk("held_pnd_e1", {24'b0, pnd}, 32'h01);
        chk("held_vld_e1", {31'b0, vld}, 32'h0);
        tick();
        chk("held_vld_e2", {31'b0, vld}, 32'h1);
        chk("held_sel_e2", {29'b0, sel}, 32'h0);
        tick();
        chk("held_hold_vld", {31'b0, vld}, 32'h1);
        ack = 1'b1;
        tick();
        chk("held_ack_pnd", {24'b0, pnd}, 32'h00);
        chk("held_ack_vld", {31'b0, vld}, 32'h0);
        ack = 1'b0;
        tick();
        chk("held_no_reset_pnd", {24'b0, pnd}, 32'h00);
        chk("held_no_reoffer", {31'b0, vld}, 32'h0);
        req = 8'h00;
        tick();

        // Two requests in one pulse: 5 first, then 2; higher arrival during offer does not retract.
        req = 8'h24;
        tick();
        chk("p24_pnd", {24'b0, pnd}, 32'h24);
        chk("p24_vld0", {31'b0, vld}, 32'h0);
        req = 8'h00;
        tick();
        chk("p24_vld", {31'b0, vld}, 32'h1);
        chk("p24_sel5", {29'b0, sel}, 32'h5);
        ack = 1'b1;
        tick();
        chk("p24_ack_pnd", {24'b0, pnd}, 32'h04);
        chk("p24_gap_vld", {31'b0, vld}, 32'h0);
        ack = 1'b0;
        tick();
        chk("p24_sel2", {29'b0, sel}, 32'h2);
        chk("p24_vld2", {31'b0, vld}, 32'h1);
        req = 8'h80;
        tick();
        req = 8'h00;
        chk("b7_pnd", {24'b0, pnd}, 32'h84);
        chk("b7_sel_frozen", {29'b0, sel}, 32'h2);
        tick();
        chk("b7_sel_frozen2", {29'b0, sel}, 32'h2);
        ack = 1'b1;
        tick();
        chk("b7_ack_pnd", {24'b0, pnd}, 32'h80);
        ack = 1'b0;
        tick();
        chk("b7_sel7", {29'b0, sel}, 32'h7);
        chk("b7_vld", {31'b0, vld}, 32'h1);
        ack = 1'b1;
        tick();
        chk("b7_done_pnd", {24'b0, pnd}, 32'h00);
        chk("b7_done_vld", {31'b0, vld}, 32'h0);
        ack = 1'b0;

        // Masked bit 7 with bits 7 and 1 pending.
        msk = 8'h80; req = 8'h82;
        tick();
        chk("m_pnd", {24'b0, pnd}, 32'h82);
        req = 8'h00;
        tick();
        chk("m_sel1", {29'b0, sel}, 32'h1);
        ack = 1'b1;
        tick();
        chk("m_ack_pnd", {24'b0, pnd}, 32'h80);
        ack = 1'b0;
        tick();
        chk("m_masked_vld", {31'b0, vld}, 32'h0);
        ack = 1'b1;
        tick();
        chk("m_idle_ack_pnd", {24'b0, pnd}, 32'h80);
        chk("m_idle_ack_vld", {31'b0, vld}, 32'h0);
        ack = 1'b0; msk = 8'h00;
        tick();
        chk("m_unmask_vld", {31'b0, vld}, 32'h1);
        chk("m_unmask_sel7", {29'b0, sel}, 32'h7);
        chk("m_unmask_pnd", {24'b0, pnd}, 32'h80);
        msk = 8'h80;
        tick();
        chk("m_remask_hold", {31'b0, vld}, 32'h1);
        ack = 1'b1;
        tick();
        chk("m_final_pnd", {24'b0, pnd}, 32'h00);
        ack = 1'b0; msk = 8'h00;

        // Ack coinciding with a new rise on the same bit re-pends it; then reset during offer.
        req = 8'h08;
        tick();
        req = 8'h00;
        tick();
        chk("rp_sel3", {29'b0, sel}, 32'h3);
        ack = 1'b1; req = 8'h08;
        tick();
        chk("rp_pnd", {24'b0, pnd}, 32'h08);
        chk("rp_vld0", {31'b0, vld}, 32'h0);
        ack = 1'b0; req = 8'h00;
        tick();
        chk("rp_reoffer_vld", {31'b0, vld}, 32'h1);
        chk("rp_reoffer_sel", {29'b0, sel}, 32'h3);
        rst = 1'b1; ack = 1'b1;
        tick();
        chk("rst_offer_vld", {31'b0, vld}, 32'h0);
        chk("rst_offer_pnd", {24'b0, pnd}, 32'h00);
        chk("rst_offer_sel", {29'b0, sel}, 32'h0);
        rst = 1'b0; ack = 1'b0;
        tick();

        // Priority order with 6,4,2 pending under continuous ack.
        req = 8'h54;
        tick();
        req = 8'h00;
        tick();
        chk("pr_sel6", {29'b0, sel}, 32'h6);
        ack = 1'b1;
        tick();
        chk("pr_pnd14", {24'b0, pnd}, 32'h14);
        tick();
        chk("pr_sel4", {29'b0, sel}, 32'h4);
        tick();
        tick();
        chk("pr_sel2", {29'b0, sel}, 32'h2);
        tick();
        chk("pr_pnd0", {24'b0, pnd}, 32'h00);
        ack = 1'b0;

        // Bit 6 re-pended as its grant is acked.
        req = 8'h54;
        tick();
        req = 8'h00;
        tick();
        chk("rr_sel6", {29'b0, sel}, 32'h6);
        ack = 1'b1; req = 8'h40;
        tick();
        chk("rr_pnd54", {24'b0, pnd}, 32'h54);
        ack = 1'b0; req = 8'h00;
        tick();
`ifdef IRQ_ENCODER_ROTATE_EN
        chk("rr_second", {29'b0, sel}, 32'h4);
        ack = 1'b1; tick(); ack = 1'b0; tick();
        chk("rr_third", {29'b0, sel}, 32'h2);
        ack = 1'b1; tick(); ack = 1'b0; tick();
        chk("rr_fourth", {29'b0, sel}, 32'h6);
`else
        chk("rr_second", {29'b0, sel}, 32'h6);
        ack = 1'b1; tick(); ack = 1'b0; tick();
        chk("rr_third", {29'b0, sel}, 32'h4);
        ack = 1'b1; tick(); ack = 1'b0; tick();
        chk("rr_fourth", {29'b0, sel}, 32'h2);
`endif
        ack = 1'b1;
        tick();
        chk("rr_pnd0", {24'b0, pnd}, 32'h00);
        ack = 1'b0;

        // 1-cold instance: idle high, bit 6 pulled low.
        chk("cold_idle_pnd", {24'b0, pnd_c}, 32'h00);
        req_c = 8'hBF;
        tick();
        chk("cold_pnd40", {24'b0, pnd_c}, 32'h40);
        req_c = 8'hFF;
        tick();
        chk("cold_vld", {31'b0, vld_c}, 32'h1);
        chk("cold_sel6", {29'b0, sel_c}, 32'h6);
        ack_c = 1'b1;
        tick();
        chk("cold_ack_pnd", {24'b0, pnd_c}, 32'h00);
        ack_c = 1'b0; msk_c = 8'hBF; req_c = 8'hBF;
        tick();
        req_c = 8'hFF;
        tick();
        chk("cold_masked_vld", {31'b0, vld_c}, 32'h0);
        chk("cold_masked_pnd", {24'b0, pnd_c}, 32'h40);
        msk_c = 8'hFF;
        tick();
        chk("cold_unmask_vld", {31'b0, vld_c}, 32'h1);
        chk("cold_unmask_sel", {29'b0, sel_c}, 32'h6);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/irq_encoder.md
Name: irq_encoder

Overview:
- Registered priority encoder with request latching; the inverse of the decoder block. It turns N request lines into a binary index.
- Sits in front of the 8085 core's interrupt/RST vector logic.
- Latches edge-detected requests into a pending register and applies a mask.
- Offers the highest-priority pending index with a valid/ack handshake, then clears the serviced bit.

Parameters:
- SEL_SIZE, 3, width of encoded index output
- REQ_SIZE, 2**SEL_SIZE, number of request lines (derived; not overridden independently)
- ONE_COLD, 0, 1 = iREQ and iMSK are active-low (mirrors the decoder's 1-cold mode); 0 = active-high

Ports:
- iCLK  input  1  clock, all state updates on rising edge
- iRST  input  1  reset, synchronous, active-high
- iREQ  input  REQ_SIZE  request lines, polarity per ONE_COLD
- iMSK  input  REQ_SIZE  mask, asserted bit blocks that request from being offered, polarity per ONE_COLD
- iACK  input  1  consumer accepts the offered index, active-high
- oVLD  output  1  offered index valid, active-high
- oSEL  output  SEL_SIZE  encoded index of the offered request
- oPND  output  REQ_SIZE  pending register, always active-high regardless of ONE_COLD

Behaviour:
- Normalise inputs: req = ONE_COLD ? ~iREQ : iREQ; msk = ONE_COLD ? ~iMSK : iMSK.
- Reset (iRST high at edge):
  - Register values: oVLD=0, oSEL=0, oPND=0, req_prev=0, state=IDLE.
  - Takes priority over every other event, including iACK and new edges.
- Edge detect: rise = req & ~req_prev; req_prev <= req every edge.
  - A line held asserted through reset produces exactly one rise after reset.
  - A line held asserted produces no further sets.
- Pending update each edge: pnd <= (pnd & ~clr) | rise.
  - clr is the one-hot of oSEL when an ack is taken, else 0.
  - Set wins over clear on the same bit: a new rise coinciding with the ack re-pends that bit.
- eligible = pnd & ~msk. Masking never clears pnd; unmasking a pending bit makes it eligible next cycle.
- Priority: highest index wins (bit REQ_SIZE-1 highest). Computed combinationally from eligible.
- FSM, 2 states:
  - IDLE: oVLD=0. If eligible != 0 at edge: oSEL <= winning index, oVLD <= 1, go OFFER.
  - OFFER: oVLD=1, oSEL frozen.
    - Later requests, mask changes or higher-priority arrivals do not retract or change the offer.
    - On iACK=1 at edge: clear pnd[oSEL], oVLD <= 0, go IDLE.
  - iACK in IDLE is ignored, with no pnd change.
- Latency:
  - req asserted before edge k -> oPND bit set after edge k -> oVLD=1 after edge k+1.
  - After an ack, at least one cycle of oVLD=0 precedes the next offer. Back-to-back grant spacing is 2 cycles minimum.
- oSEL retains its last value while oVLD=0; consumers ignore it.
- All outputs are registered; no combinational path from inputs to outputs.

Optional Feature:
- Macro IRQ_ENCODER_ROTATE_EN.
- Defined:
  - Priority is round-robin. Keep a SEL_SIZE-bit last-granted register, reset to REQ_SIZE-1.
  - In IDLE, the winner is the first eligible index searched downward, starting at last-1 modulo REQ_SIZE and wrapping 0 -> REQ_SIZE-1.
  - The register updates to oSEL when the ack is taken.
  - With a single eligible bit, the result is identical to fixed priority.
- Undefined:
  - Fixed highest-index priority.
  - The last-granted register and its logic are absent.

Test Plan:
- Reset with iREQ=8'h01 held (ONE_COLD=0), release reset -> oPND=8'h01 after 1st edge, oVLD=1 with oSEL=0 after 2nd edge. No second set while held.
- Pulse iREQ=8'h24 in one cycle, iMSK=0 -> offer oSEL=5; ack -> oPND=8'h04, one idle cycle; offer oSEL=2; ack -> oPND=0, oVLD=0.
- Offer oSEL=2 pending, then pulse req bit 7 before the ack -> oSEL stays 2 until ack; next offer is oSEL=7.
- iMSK=8'h80 with bits 7 and 1 pending -> offer oSEL=1. Drop mask after ack -> offer oSEL=7. oPND bit 7 remains set throughout.
- Ack of oSEL=3 in the same cycle as a new rise on bit 3 -> oPND bit 3 stays 1, re-offered oSEL=3. Assert iRST during OFFER -> next cycle oVLD=0, oPND=0.
- ONE_COLD=1 with iREQ idle at 8'hFF, drive 8'hBF -> oPND=8'h40, oSEL=6. With IRQ_ENCODER_ROTATE_EN and bits 6, 4, 2 pending -> grant order 6, 4, 2 under continuous ack; with bit 6 re-pended after its grant, order is 6, 4, 2, 6.
